// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
//
// Purpose:
//   Runs one APB transfer per core command. The decoder supplies the device
//   index, register address and write data. The controller drives the APB
//   SETUP and ACCESS phases and waits for pready. It then returns read data or
//   an error to the core as a single-cycle response. A slave that holds pready
//   low for TIMEOUT ACCESS cycles is abandoned and reported as an error.
//
// Handshake:
//   A command transfers on a rising edge where cmd_valid && cmd_ready.
//   cmd_ready is high only in IDLE. While cmd_ready is low, cmd_* is ignored.
//   The response is a one-cycle rsp_valid pulse with no backpressure.
//   rsp_rdata and rsp_err are meaningful only while rsp_valid is high.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake
//   cmd_write         1 = write, 0 = read
//   cmd_device        target slave index (4 bits)
//   cmd_addr          register address (ADDR_W)
//   cmd_wdata         write data (DATA_W)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         read data; 0 for writes and for errors
//   rsp_err           slave error, bad device or timeout
//   psel..pwdata      APB master outputs (psel is one-hot, NUM_DEV wide)
//   prdata, pready,
//   pslverr           APB slave returns
//   dbg_state         current FSM state (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
// -----------------------------------------------------------------------------
module apb_master_ctrl #(
    parameter int NUM_DEV = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [3:0]        cmd_device,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [NUM_DEV-1:0] psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [1:0]        dbg_state
);

    // The counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               dev_ok;
    logic [NUM_DEV-1:0] dev_onehot;

    assign cmd_ready = (state == IDLE);
    assign dbg_state = state;

    // Out-of-range device indices never reach the bus.
    assign dev_ok = (int'(cmd_device) < NUM_DEV);

    always_comb begin
        dev_onehot = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (int'(cmd_device) == i) begin
                dev_onehot[i] = 1'b1;
            end
        end
    end

    // All bus and response outputs are registered. psel is loaded at accept,
    // so it is already valid during the SETUP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        if (dev_ok) begin
                            psel  <= dev_onehot;
                            state <= SETUP;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        // A completed transfer has priority over the timeout.
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= (pwrite || pslverr) ? '0 : prdata;
                        state     <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    rsp_valid <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= IDLE;
                end

                default: begin
                    psel      <= '0;
                    penable   <= 1'b0;
                    rsp_valid <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
//
// Directed bench for apb_master_ctrl (NUM_DEV=4, ADDR_W=8, DATA_W=8,
// TIMEOUT=15). Cycle offsets count periods after the accept edge. The period
// that follows the accept edge is offset 1.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_device;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [3:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected response: {err, rdata}
    logic [8:0] exp_q[$];

    apb_master_ctrl #(
        .NUM_DEV(4),
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_device(cmd_device),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver: one full transfer with slave model ----------------
    task automatic run_txn(
        input logic       wr,
        input logic [3:0] dev,
        input logic [7:0] addr,
        input logic [7:0] wdata,
        input int         waits,
        input logic [7:0] srd,
        input logic       serr,
        input int         exp_lat,
        input logic [3:0] exp_psel,
        input logic [7:0] exp_rd,
        input logic       exp_err
    );
        logic [8:0] exp;
        int         acc;
        bit         seen;
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_device = dev;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        @(posedge clk);
        #1;
        // Scramble the command bus while busy; it must be ignored.
        cmd_valid  = 1'b0;
        cmd_write  = ~wr;
        cmd_device = 4'($urandom_range(0, 15));
        cmd_addr   = 8'($urandom_range(0, 255));
        cmd_wdata  = 8'($urandom_range(0, 255));
        acc  = 0;
        seen = 0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (psel != 4'd0 && penable) begin
                pready  = (acc >= waits);
                prdata  = pready ? srd : 8'hC3;
                pslverr = pready & serr;
                acc++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = 8'hE7;
            end
            check("busy_ready", cmd_ready, 0);
            if (psel != 4'd0) begin
                check("psel_dev", psel, exp_psel);
                check("paddr_stable", paddr, addr);
                check("pwdata_stable", pwdata, wdata);
                check("pwrite_stable", pwrite, wr);
            end
            if (exp_psel == 4'd0) check("no_psel", psel, 0);
            if (penable) check("pen_needs_psel", psel != 4'd0, 1);
            if (cyc == 1 && exp_psel != 4'd0) begin
                check("setup_psel", psel, exp_psel);
                check("setup_pen", penable, 0);
            end
            if (cyc == 2 && exp_psel != 4'd0) check("access_pen", penable, 1);
            if (rsp_valid) begin
                seen = 1;
                exp  = exp_q.pop_front();
                check("rsp_lat", cyc, exp_lat);
                check("rsp_rdata", rsp_rdata, exp[7:0]);
                check("rsp_err", rsp_err, exp[8]);
                check("resp_psel", psel, 0);
                check("resp_pen", penable, 0);
                check("resp_state", dbg_state, 3);
            end
        end
        check("rsp_seen", seen, 1);
        if (!seen) exp_q.delete();
        @(negedge clk);
        pready  = 1'b0;
        pslverr = 1'b0;
        check("ready_after", cmd_ready, 1);
        check("rsp_pulse", rsp_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    int         acc_at[2];
    int         rsp_at[2];
    logic [7:0] rsp_rd[2];
    logic       rsp_er[2];
    logic [7:0] rsp_pa[2];
    int         n_acc;
    int         n_rsp;
    bit         pend;

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_device = 4'd0;
        cmd_addr   = 8'd0;
        cmd_wdata  = 8'd0;
        prdata     = 8'd0;
        pready     = 1'b0;
        pslverr    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        //       wr  dev    addr   wdata  waits srd    serr lat psel     rd     err
        run_txn(1'b1, 4'd2, 8'h10, 8'hA5, 0,   8'h99, 1'b0, 3, 4'b0100, 8'h00, 1'b0);
        run_txn(1'b0, 4'd1, 8'h3C, 8'h00, 3,   8'h5E, 1'b0, 6, 4'b0010, 8'h5E, 1'b0);
        run_txn(1'b0, 4'd0, 8'h07, 8'h00, 0,   8'h00, 1'b1, 3, 4'b0001, 8'h00, 1'b1);
        run_txn(1'b1, 4'd3, 8'h81, 8'h6D, 1,   8'h77, 1'b1, 4, 4'b1000, 8'h00, 1'b1);
        run_txn(1'b0, 4'd3, 8'h55, 8'h00, 100, 8'h12, 1'b0, 17, 4'b1000, 8'h00, 1'b1);
        run_txn(1'b0, 4'd3, 8'hF0, 8'h00, 14,  8'hC9, 1'b0, 17, 4'b1000, 8'hC9, 1'b0);
        run_txn(1'b1, 4'd9, 8'h20, 8'h33, 0,   8'h00, 1'b0, 1, 4'b0000, 8'h00, 1'b1);
        run_txn(1'b0, 4'd4, 8'h21, 8'h00, 0,   8'h00, 1'b0, 1, 4'b0000, 8'h00, 1'b1);
        run_txn(1'b0, 4'd0, 8'hFF, 8'h00, 0,   8'hA3, 1'b0, 3, 4'b0001, 8'hA3, 1'b0);

        // Reset in the middle of ACCESS
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_device = 4'd2;
        cmd_addr   = 8'h44;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pready = 1'b0;
        check("mid_access_pen", penable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_psel", psel, 0);
        check("arst_pen", penable, 0);
        check("arst_state", dbg_state, 0);
        check("arst_paddr", paddr, 0);
        repeat (2) begin
            @(negedge clk);
            check("arst_no_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_rsp", rsp_valid, 0);
        check("post_rst_ready", cmd_ready, 1);

        // Back-to-back commands with cmd_valid held high
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 8'h77;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_device = 4'd3;
        cmd_addr   = 8'h20;
        cmd_wdata  = 8'h11;
        n_acc = 0;
        n_rsp = 0;
        pend  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid && n_rsp < 2) begin
                rsp_at[n_rsp] = c;
                rsp_rd[n_rsp] = rsp_rdata;
                rsp_er[n_rsp] = rsp_err;
                rsp_pa[n_rsp] = paddr;
                n_rsp++;
            end
            if (cmd_ready && cmd_valid && n_acc < 2) begin
                acc_at[n_acc] = c;
                n_acc++;
                pend = 1;
            end
            @(posedge clk);
            #1;
            if (pend) begin
                pend = 0;
                if (n_acc == 1) begin
                    cmd_write  = 1'b0;
                    cmd_device = 4'd0;
                    cmd_addr   = 8'h21;
                    cmd_wdata  = 8'h00;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        pready = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_rsps", n_rsp, 2);
        if (n_acc == 2) check("b2b_spacing", acc_at[1] - acc_at[0], 4);
        if (n_rsp == 2 && n_acc == 2) begin
            check("b2b_lat0", rsp_at[0] - acc_at[0], 3);
            check("b2b_lat1", rsp_at[1] - acc_at[1], 3);
            check("b2b_rd0", rsp_rd[0], 8'h00);
            check("b2b_err0", rsp_er[0], 0);
            check("b2b_addr0", rsp_pa[0], 8'h20);
            check("b2b_rd1", rsp_rd[1], 8'h77);
            check("b2b_err1", rsp_er[1], 0);
            check("b2b_addr1", rsp_pa[1], 8'h21);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
